noc_router_param: RTL

//   Parametrised single-flit mesh router: NUM_PORTS input FIFOs, dimension-ordered
//   XY route computation, per-output round-robin arbitration, credit-based flow

---
 rtl/noc_router_param.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/noc_router_param.sv
// -----------------------------------------------------------------------------
// noc_router_param -- single-flit mesh router node.
//
// Each input port owns a small FIFO. The head flit of every FIFO is routed
// X-first then Y (dimension-ordered). Every output has its own round-robin
// arbiter and a credit counter that tracks free slots downstream. Granted
// flits leave through a registered crossbar stage.
//
// Port index map: 0=N 1=S 2=E 3=W 4=L (indices >= 5 are extra local ports).
//
// Ports (top):
//   clk, rst      clock, synchronous active-high reset
//   my_x_i/my_y_i this node's mesh coordinates
//   in_data_i     packed input flits, port p at [p*DATA_W +: DATA_W]
//   in_valid_i    per-port push strobe
//   credit_o      1-cycle pulse per input: one FIFO entry freed
//   out_data_o    packed output flits, same packing as in_data_i
//   out_valid_o   per-output flit-valid
//   credit_i      1-cycle pulse per output: downstream returned a credit
//   overflow_o    sticky per-input: a flit was dropped on a full FIFO
// -----------------------------------------------------------------------------

// Per-port input FIFO. A push to a full FIFO is accepted only when the same
// cycle also pops, otherwise the flit is dropped and o_overflow latches.
module noc_in_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd;
    logic [AW-1:0]     r_wr;
    logic [CW-1:0]     r_cnt;
    logic              r_ovf;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    assign o_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CW'(DEPTH));
    assign w_pop      = i_pop & ~o_empty;
    assign w_push     = i_valid & (~w_full | w_pop);
    assign o_head     = r_mem[r_rd];
    assign o_overflow = r_ovf;

    // Storage needs no reset: the occupancy counter defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (i_valid && !w_push) r_ovf <= 1'b1;
        end
    end
endmodule

module noc_router_param #(
    parameter int NUM_PORTS  = 5,
    parameter int DATA_W     = 32,
    parameter int COORD_W    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COORD_W-1:0]            my_x_i,
    input  logic [COORD_W-1:0]            my_y_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data_i,
    input  logic [NUM_PORTS-1:0]          in_valid_i,
    output logic [NUM_PORTS-1:0]          credit_o,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    input  logic [NUM_PORTS-1:0]          credit_i,
    output logic [NUM_PORTS-1:0]          overflow_o
);
    localparam int PW  = $clog2(NUM_PORTS);
    localparam int CRW = $clog2(CREDITS) + 1;

    localparam logic [PW-1:0] P_N = PW'(0);
    localparam logic [PW-1:0] P_S = PW'(1);
    localparam logic [PW-1:0] P_E = PW'(2);
    localparam logic [PW-1:0] P_W = PW'(3);
    localparam logic [PW-1:0] P_L = PW'(4);

    logic [NUM_PORTS-1:0][DATA_W-1:0]    w_in;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    w_head;
    logic [NUM_PORTS-1:0]                w_empty;
    logic [NUM_PORTS-1:0]                w_pop;
    logic [NUM_PORTS-1:0]                w_ovf;
    logic [NUM_PORTS-1:0][PW-1:0]        w_route;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req;   // [output][input]
    logic [NUM_PORTS-1:0]                w_gvld;
    logic [NUM_PORTS-1:0][PW-1:0]        w_win;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    w_gdata;

    logic [NUM_PORTS-1:0][CRW-1:0]       r_cred;
    logic [NUM_PORTS-1:0][PW-1:0]        r_rr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    r_out_data;
    logic [NUM_PORTS-1:0]                r_out_vld;
    logic [NUM_PORTS-1:0]                r_credit;

    assign w_in        = in_data_i;
    assign out_data_o  = r_out_data;
    assign out_valid_o = r_out_vld;
    assign credit_o    = r_credit;
    assign overflow_o  = w_ovf;

    function automatic int wrap_add(input int a, input int b);
        return (a + b) % NUM_PORTS;
    endfunction

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            noc_in_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk        (clk),
                .rst        (rst),
                .i_valid    (in_valid_i[p]),
                .i_data     (w_in[p]),
                .i_pop      (w_pop[p]),
                .o_head     (w_head[p]),
                .o_empty    (w_empty[p]),
                .o_overflow (w_ovf[p])
            );
        end
    endgenerate

    // XY route of every FIFO head and the resulting request matrix.
    always_comb begin
        w_route = '0;
        w_req   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_head[p][DATA_W-1 -: COORD_W] > my_x_i)
                w_route[p] = P_E;
            else if (w_head[p][DATA_W-1 -: COORD_W] < my_x_i)
                w_route[p] = P_W;
            else if (w_head[p][DATA_W-1-COORD_W -: COORD_W] > my_y_i)
                w_route[p] = P_N;
            else if (w_head[p][DATA_W-1-COORD_W -: COORD_W] < my_y_i)
                w_route[p] = P_S;
            else
                w_route[p] = P_L;
        end
        for (int o = 0; o < NUM_PORTS; o++)
            for (int p = 0; p < NUM_PORTS; p++)
                w_req[o][p] = !w_empty[p] && (w_route[p] == PW'(o));
    end

    // Round-robin per output, gated by credit availability. Each input
    // requests exactly one output, so an input can never win twice.
    always_comb begin
        w_gvld  = '0;
        w_win   = '0;
        w_pop   = '0;
        w_gdata = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (r_cred[o] != '0) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (!w_gvld[o] && w_req[o][wrap_add(int'(r_rr[o]), k)]) begin
                        w_gvld[o] = 1'b1;
                        w_win[o]  = PW'(wrap_add(int'(r_rr[o]), k));
                    end
                end
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_gvld[o] && (w_win[o] == PW'(p))) begin
                    w_pop[p]   = 1'b1;
                    w_gdata[o] = w_head[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= '0;
            r_out_data <= '0;
            r_credit   <= '0;
            r_rr       <= '0;
            for (int o = 0; o < NUM_PORTS; o++)
                r_cred[o] <= CRW'(CREDITS);
        end else begin
            r_out_vld <= w_gvld;
            r_credit  <= w_pop;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_gvld[o]) begin
                    r_out_data[o] <= w_gdata[o];
                    r_rr[o]       <= (w_win[o] == PW'(NUM_PORTS-1)) ? '0 : w_win[o] + 1'b1;
                end
                // Send and return in the same cycle cancel; returns saturate.
                if (w_gvld[o] && !credit_i[o])
                    r_cred[o] <= r_cred[o] - 1'b1;
                else if (!w_gvld[o] && credit_i[o] && (r_cred[o] < CRW'(CREDITS)))
                    r_cred[o] <= r_cred[o] + 1'b1;
            end
        end
    end
endmodule
